bttn_operand_entry: RTL
=======================

// Module: bttn_operand_entry
// PURPOSE
//  Front end that builds the bttn ALU's operand inputs from two physical push buttons.
//  The user steps through the fields A, B, opCodeA and select. Each field is edited
//  in a shadow register. The completed operand set goes to the ALU atomically on commit.
//  Sits between the board buttons and the bttn instance; its outputs drive bttn's A/B/opCodeA/select.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable sync samples needed to accept a button level change
//  BTN_ACTIVE_LOW   1       1: raw buttons read 0 when pressed; 0: read 1 when pressed
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   asynchronous, active-high reset
//  btn_inc    in   1   raw async button: increment current field
//  btn_next   in   1   raw async button: advance to next field / commit
//  A          out  4   committed operand A
//  B          out  4   committed operand B
//  opCodeA    out  3   committed opcode
//  select     out  2   committed output select
//  field      out  2   field being edited: 0=A 1=B 2=opCodeA 3=select
//  commit     out  1   one-cycle pulse when A/B/opCodeA/select update
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - outputs A, B, opCodeA, select, field and commit = 0
//   - shadow regs = 0; FSM = S_A; debouncers report "released"
//  Button path, per button:
//   - 2-FF synchroniser, then polarity normalisation to pressed=1
//   - a counter increments while sync != stable and clears when they are equal
//   - at count == DEBOUNCE_CYCLES-1, stable <= sync and the counter clears
//   - press pulse is 1 cycle, on the 0->1 transition of stable; release generates no pulse
//   - latency: pulse is high in cycle DEBOUNCE_CYCLES+3 after the raw edge is first sampled
//   - bounces shorter than DEBOUNCE_CYCLES are ignored entirely
//  FSM states: S_A, S_B, S_OP, S_SEL, S_COMMIT; field output = state index (S_COMMIT shows 3)
//   - inc pulse in S_A/S_B/S_OP/S_SEL: shadow field +1, wrapping modulo width
//     (A,B 15->0; opCodeA 7->0; select 3->0)
//   - next pulse: S_A->S_B->S_OP->S_SEL->S_COMMIT
//   - S_COMMIT lasts exactly 1 cycle:
//     - outputs <= shadow values and commit = 1 on the following clock edge
//     - then S_A; shadow regs are retained, so the next entry edits from the last values
//   - inc and next pulses in the same cycle: next wins, inc is discarded
//   - pulses arriving during S_COMMIT are discarded
//   - outputs A/B/opCodeA/select never change except at commit; they are glitch-free registers
//  Reset mid-entry: shadow edits are lost; committed outputs return to 0; no commit pulse.
// STRUCTURE
//  Shared package bttn_pkg:
//   - field width constants W_A=4, W_B=4, W_OP=3, W_SEL=2
//   - FSM state encoding localparams S_A..S_COMMIT (3-bit)
//   - FIELD_* index constants
//  Sub-module btn_debounce (parameters DEBOUNCE_CYCLES, ACTIVE_LOW;
//   ports clk, rst, raw, pressed, press_pulse), instantiated twice.
//  Top: FSM, shadow regs, output regs. Counter width = $clog2(DEBOUNCE_CYCLES)+1.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset, then idle 50 cycles -> A=B=0, opCodeA=0, select=0, field=0, commit never high.
//  2. btn_inc bounce (pressed 2 cycles, released 2, pressed 20) -> exactly one A increment,
//     timed DEBOUNCE_CYCLES+3 cycles after the stable press begins.
//  3. Entry sequence:
//     - inc A x15, next, inc B x1, next, inc op x1, next, inc sel x3, next
//     - expect a single commit with A=4'b1111, B=4'b0001, opCodeA=3'b001, select=2'b11, then field=0
//  4. Wrap: inc A 17 times then commit -> A=4'b0001; inc select 5 times -> select=2'b01.
//  5. Simultaneous pulse: force inc and next press pulses in the same cycle while in S_A
//     -> field goes 0->1, shadow A unchanged.
//  6. Assert rst while in S_OP with edited shadows -> all outputs 0 immediately (async), field=0;
//     next full sequence commits only the newly entered values.

Source files
------------

// File: rtl/bttn_pkg.sv
// rtl/bttn_pkg.sv - shared widths, FSM encoding and field indices for the bttn operand front end
package bttn_pkg;

  localparam int W_A   = 4;
  localparam int W_B   = 4;
  localparam int W_OP  = 3;
  localparam int W_SEL = 2;

  localparam logic [2:0] S_A      = 3'd0;
  localparam logic [2:0] S_B      = 3'd1;
  localparam logic [2:0] S_OP     = 3'd2;
  localparam logic [2:0] S_SEL    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [1:0] FIELD_A   = 2'd0;
  localparam logic [1:0] FIELD_B   = 2'd1;
  localparam logic [1:0] FIELD_OP  = 2'd2;
  localparam logic [1:0] FIELD_SEL = 2'd3;

  // The commit state keeps showing the select field.
  function automatic logic [1:0] state_to_field(input logic [2:0] s);
    case (s)
      S_A:     return FIELD_A;
      S_B:     return FIELD_B;
      S_OP:    return FIELD_OP;
      default: return FIELD_SEL;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise, normalise and debounce one raw button; one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pressed,
  output logic press_pulse
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           IDLE_LVL = ACTIVE_LOW;

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;
  logic          w_level;

  // Sync flops start at the released raw level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= IDLE_LVL;
      r_sync <= IDLE_LVL;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
    end
  end

  assign w_level = ACTIVE_LOW ? ~r_sync : r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (w_level == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= w_level;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
    end
  end

  assign pressed     = r_stable;
  assign press_pulse = r_pulse;

endmodule

// File: rtl/bttn_operand_entry.sv
// rtl/bttn_operand_entry.sv - two-button operand entry: shadow edit of A/B/opCodeA/select, atomic commit
module bttn_operand_entry import bttn_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_next,
  output logic [W_A-1:0]   A,
  output logic [W_B-1:0]   B,
  output logic [W_OP-1:0]  opCodeA,
  output logic [W_SEL-1:0] select,
  output logic [1:0]       field,
  output logic             commit
);

  logic             r_rst_meta;
  logic             r_rst_sync;
  logic             w_inc_pulse;
  logic             w_next_pulse;
  logic             w_inc_en;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [W_A-1:0]   r_sh_a;
  logic [W_B-1:0]   r_sh_b;
  logic [W_OP-1:0]  r_sh_op;
  logic [W_SEL-1:0] r_sh_sel;
  logic [W_A-1:0]   r_a;
  logic [W_B-1:0]   r_b;
  logic [W_OP-1:0]  r_op;
  logic [W_SEL-1:0] r_sel;
  logic             r_commit;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_inc (
    .clk         (clk),
    .rst         (r_rst_sync),
    .raw         (btn_inc),
    .pressed     (),
    .press_pulse (w_inc_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_next (
    .clk         (clk),
    .rst         (r_rst_sync),
    .raw         (btn_next),
    .pressed     (),
    .press_pulse (w_next_pulse)
  );

  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) r_state <= S_A;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_A:      if (w_next_pulse) w_state_nxt = S_B;
      S_B:      if (w_next_pulse) w_state_nxt = S_OP;
      S_OP:     if (w_next_pulse) w_state_nxt = S_SEL;
      S_SEL:    if (w_next_pulse) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_A;
      default:  w_state_nxt = S_A;
    endcase
  end

  // next beats inc in the same cycle; anything landing in S_COMMIT is dropped.
  always_comb begin
    field    = state_to_field(r_state);
    w_inc_en = w_inc_pulse & ~w_next_pulse & (r_state != S_COMMIT);
  end

  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_sh_op  <= '0;
      r_sh_sel <= '0;
    end else if (w_inc_en) begin
      case (r_state)
        S_A:     r_sh_a   <= r_sh_a + 1'b1;
        S_B:     r_sh_b   <= r_sh_b + 1'b1;
        S_OP:    r_sh_op  <= r_sh_op + 1'b1;
        S_SEL:   r_sh_sel <= r_sh_sel + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sel    <= '0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        r_a   <= r_sh_a;
        r_b   <= r_sh_b;
        r_op  <= r_sh_op;
        r_sel <= r_sh_sel;
      end
    end
  end

  assign A       = r_a;
  assign B       = r_b;
  assign opCodeA = r_op;
  assign select  = r_sel;
  assign commit  = r_commit;

endmodule
